// File: rtl/bus_fifo_slave.sv
// bus_fifo_slave: 32-bit write FIFO behind a single-cycle bus slave port.
// The FIFO is drained through a valid/ready stream. The slave port also holds
// status, control (clear, interrupt enable, low-watermark threshold) and a
// sticky overflow flag.
module bus_fifo_slave #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic [7:0]  s_address,
    input  logic        s_wr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        irq
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_ERR    = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] thresh_q, thresh_d;
    logic          ie_q, ie_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   dout_q, dout_d;

    logic          full, empty;
    logic          wr_data, wr_ctrl, wr_err, rd_acc;
    logic          push, pop, clear, ovf_set;
    logic [31:0]   rd_data;
    logic          unused_addr_hi;

    // Upper address bits do not take part in the decode.
    assign unused_addr_hi = ^s_address[7:2];

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign out_data  = empty ? 32'h0 : mem[rd_ptr_q];
    assign irq       = ie_q & (count_q <= thresh_q);
    assign s_dout    = dout_q;

    assign wr_data = s_sel & s_wr & (s_address[1:0] == ADDR_DATA);
    assign wr_ctrl = s_sel & s_wr & (s_address[1:0] == ADDR_CTRL);
    assign wr_err  = s_sel & s_wr & (s_address[1:0] == ADDR_ERR);
    assign rd_acc  = s_sel & ~s_wr;

    // A pop never makes room for a push that arrives while full.
    assign clear   = wr_ctrl & s_din[0];
    assign push    = wr_data & ~full;
    assign ovf_set = wr_data & full;
    assign pop     = out_valid & out_ready;

    // Read mux; sampled into s_dout at the access edge, so it reflects pre-edge state.
    always_comb begin
        rd_data = 32'h0;
        case (s_address[1:0])
            ADDR_DATA:   rd_data = out_data;
            ADDR_STATUS: rd_data = (32'(count_q) << 8) | {30'h0, full, empty};
            ADDR_CTRL:   rd_data = (32'(thresh_q) << 8) | {30'h0, ie_q, 1'b0};
            ADDR_ERR:    rd_data = {31'h0, ovf_q};
            default:     rd_data = 32'h0;
        endcase
    end

    // Next-state for pointers, count, control and error registers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ie_d     = ie_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        dout_d   = dout_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (wr_ctrl) begin
            ie_d     = s_din[1];
            thresh_d = s_din[8 +: CW];
        end

        // Set takes priority over a coincident write-one-to-clear.
        if (wr_err && s_din[0]) ovf_d = 1'b0;
        if (ovf_set)            ovf_d = 1'b1;

        if (rd_acc) dout_d = rd_data;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ie_q     <= 1'b0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            dout_q   <= 32'h0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ie_q     <= ie_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
        end
    end

    // FIFO storage is not reset; a push discarded by CLEAR is harmless since pointers reset.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= s_din;
    end

endmodule
